fsm_arb_ctrl: RTL

- Registered-output FSM arbiter that shares one downstream resource among N requesters.
- Sequences each ownership through four states: arbitrate, grant, hold with a bounded timer, then a one-cycle turnaround.
- Sits in front of any single-owner datapath in the bench, alongside the other small state-machine controllers.
- All outputs come from flops; no combinational path runs from inputs to outputs.

---
 rtl/fsm_arb_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fsm_arb_ctrl.sv
// Registered-output FSM arbiter: IDLE -> ARB -> OWN (bounded hold) -> LAST, grant 2 cycles after request.
// Winner selection is fixed lowest-index priority unless FAIR_RR_EN is defined (round-robin from last owner).
module fsm_arb_ctrl #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int CW      = 8,
  parameter int MAXHOLD = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] OWN  = 2'd2;
  localparam logic [1:0] LAST = 2'd3;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1);

  logic [1:0]     state, nstate;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IDW-1:0] last_owner, winner, id_nxt;
  logic           to_nxt;

  // gnt_id doubles as the owner register; it only changes on a successful arbitration.
`ifdef FAIR_RR_EN
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(last_owner) + 1 + k) % N;
      if (!found && req[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) winner = IDW'(k);
    end
  end

  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;
`endif

  always_comb begin
    nstate  = state;
    cnt_nxt = cnt;
    id_nxt  = gnt_id;
    to_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) nstate = ARB;
      end
      ARB: begin
        if (|req) begin
          nstate  = OWN;
          id_nxt  = winner;
          cnt_nxt = '0;
        end else begin
          nstate = IDLE;
        end
      end
      OWN: begin
        if (done || !req[gnt_id] || (cnt == HOLD_LAST)) begin
          nstate  = LAST;
          cnt_nxt = '0;
          // Timeout only when the limit alone ended the ownership.
          to_nxt  = !done && req[gnt_id];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LAST: begin
        cnt_nxt = '0;
        nstate  = (|req) ? ARB : IDLE;
      end
      default: begin
        nstate  = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_id     <= '0;
      last_owner <= IDW'(N - 1);
      grant      <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state   <= nstate;
      cnt     <= cnt_nxt;
      gnt_id  <= id_nxt;
      if (state == LAST) last_owner <= gnt_id;
      grant   <= (nstate == OWN) ? (ONE_HOT0 << id_nxt) : '0;
      busy    <= (nstate != IDLE);
      timeout <= to_nxt;
    end
  end

endmodule
